// File: rtl/mul_result_queue.sv
// mul_result_queue: in-order result buffer between the pipelined multiplier
// and the CDB arbiter. It tracks issue credits (mq_free) so that ops in flight
// plus queued results never exceed DEPTH. On squash it discards queued results
// and the results that are still in flight.
// Optional feature macro: MUL_QUEUE_BYPASS_EN. When it is defined, an arrival
// into an empty queue drives mq_* in the same cycle.
module mul_result_queue #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned CNT_W   = $clog2(DEPTH + 1),
   parameter int unsigned XLEN    = 32,
   parameter int unsigned PRF_LEN = 6,
   parameter int unsigned ROB_LEN = 5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               mul_enable,
   input  logic               mul_valid,
   input  logic [XLEN-1:0]    mul_value,
   input  logic [PRF_LEN-1:0] mul_prf_idx,
   input  logic [ROB_LEN-1:0] mul_rob_idx,
   input  logic [XLEN-1:0]    mul_PC,
   input  logic               squash,
   input  logic               cdb_grant,
   output logic               mq_valid,
   output logic [XLEN-1:0]    mq_value,
   output logic [PRF_LEN-1:0] mq_prf_idx,
   output logic [ROB_LEN-1:0] mq_rob_idx,
   output logic [XLEN-1:0]    mq_PC,
   output logic               mq_free,
   output logic [CNT_W-1:0]   mq_count,
   output logic               mq_overflow
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   pending_q, pending_d;
   logic [CNT_W-1:0]   drop_q, drop_d;
   logic               overflow_q, overflow_d;

   logic [XLEN-1:0]    value_q [DEPTH];
   logic [PRF_LEN-1:0] prf_q   [DEPTH];
   logic [ROB_LEN-1:0] rob_q   [DEPTH];
   logic [XLEN-1:0]    pc_q    [DEPTH];

   logic               arrive_ok, empty, full, bypass_hit, byp_taken;
   logic               push, pop, lost;
   logic [CNT_W:0]     pend_wide;
   logic [CNT_W-1:0]   pend_next;

   // Arrival/grant decode and pending-credit arithmetic
   always_comb begin
      arrive_ok = mul_valid && !squash && (drop_q == '0);
      empty     = (count_q == '0);
      full      = (count_q == CNT_W'(DEPTH));
`ifdef MUL_QUEUE_BYPASS_EN
      bypass_hit = arrive_ok && empty;
`else
      bypass_hit = 1'b0;
`endif
      // A bypassed result granted in its arrival cycle never occupies a slot
      byp_taken = bypass_hit && cdb_grant;
      pop       = cdb_grant && !squash && !empty;
      push      = arrive_ok && !byp_taken && (!full || pop);
      lost      = arrive_ok && full && !pop;

      // pending + mul_enable - mul_valid, clamped at zero and at the counter range
      pend_wide = {1'b0, pending_q} + (CNT_W + 1)'(mul_enable);
      if (mul_valid && (pend_wide != '0)) begin
         pend_wide = pend_wide - (CNT_W + 1)'(1);
      end
      pend_next = pend_wide[CNT_W] ? '1 : pend_wide[CNT_W-1:0];
   end

   // Next-state for pointers, occupancy, credit and drop counters
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      drop_d     = drop_q;
      pending_d  = pend_next;
      overflow_d = overflow_q | lost;
      if (squash) begin
         // The drop count is reloaded from outstanding ops, never accumulated
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         drop_d  = pend_next;
      end else begin
         if (push) tail_d = tail_q + PTR_W'(1);
         if (pop)  head_d = head_q + PTR_W'(1);
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
         end
         if (mul_valid && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1);
         end
      end
   end

   // Control state registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         pending_q  <= '0;
         drop_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         pending_q  <= pending_d;
         drop_q     <= drop_d;
         overflow_q <= overflow_d;
      end
   end

   // Payload storage; contents are only observed through an occupied head
   always_ff @(posedge clock) begin
      if (push) begin
         value_q[tail_q] <= mul_value;
         prf_q[tail_q]   <= mul_prf_idx;
         rob_q[tail_q]   <= mul_rob_idx;
         pc_q[tail_q]    <= mul_PC;
      end
   end

   // Output drive: head entry, same-cycle bypass, or zeros when idle
   always_comb begin
      mq_valid    = !empty || bypass_hit;
      mq_value    = '0;
      mq_prf_idx  = '0;
      mq_rob_idx  = '0;
      mq_PC       = '0;
      if (bypass_hit) begin
         mq_value   = mul_value;
         mq_prf_idx = mul_prf_idx;
         mq_rob_idx = mul_rob_idx;
         mq_PC      = mul_PC;
      end else if (!empty) begin
         mq_value   = value_q[head_q];
         mq_prf_idx = prf_q[head_q];
         mq_rob_idx = rob_q[head_q];
         mq_PC      = pc_q[head_q];
      end
      mq_free     = ({1'b0, count_q} + {1'b0, pending_q}) < (CNT_W + 1)'(DEPTH);
      mq_count    = count_q;
      mq_overflow = overflow_q;
   end

endmodule

// File: tb/tb_mul_result_queue.sv
// Testbench for mul_result_queue. It contains a fixed-latency multiplier
// stand-in, a queue-based reference model and a scoreboard monitor.
// Expectations follow MUL_QUEUE_BYPASS_EN when that macro is defined.
module tb_mul_result_queue;

   localparam int DEPTH   = 4;
   localparam int CNT_W   = 3;
   localparam int XLEN    = 32;
   localparam int PRF_LEN = 6;
   localparam int ROB_LEN = 5;
   localparam int LAT     = 8;

   typedef struct packed {
      logic [XLEN-1:0]    value;
      logic [PRF_LEN-1:0] prf;
      logic [ROB_LEN-1:0] rob;
      logic [XLEN-1:0]    pc;
   } ent_t;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic               mul_enable = 1'b0, mul_valid = 1'b0, squash = 1'b0, cdb_grant = 1'b0;
   logic [XLEN-1:0]    mul_value = '0, mul_PC = '0;
   logic [PRF_LEN-1:0] mul_prf_idx = '0;
   logic [ROB_LEN-1:0] mul_rob_idx = '0;
   logic               mq_valid, mq_free, mq_overflow;
   logic [XLEN-1:0]    mq_value, mq_PC;
   logic [PRF_LEN-1:0] mq_prf_idx;
   logic [ROB_LEN-1:0] mq_rob_idx;
   logic [CNT_W-1:0]   mq_count;

   mul_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W), .XLEN(XLEN),
                      .PRF_LEN(PRF_LEN), .ROB_LEN(ROB_LEN)) dut (
      .clock(clock), .reset(reset),
      .mul_enable(mul_enable), .mul_valid(mul_valid), .mul_value(mul_value),
      .mul_prf_idx(mul_prf_idx), .mul_rob_idx(mul_rob_idx), .mul_PC(mul_PC),
      .squash(squash), .cdb_grant(cdb_grant),
      .mq_valid(mq_valid), .mq_value(mq_value), .mq_prf_idx(mq_prf_idx),
      .mq_rob_idx(mq_rob_idx), .mq_PC(mq_PC), .mq_free(mq_free),
      .mq_count(mq_count), .mq_overflow(mq_overflow)
   );

   always #5 clock = ~clock;

   // Reference model state
   ent_t exp_q[$];
   int   m_pending = 0;
   int   m_drop    = 0;
   bit   m_ovf     = 0;
   bit   bypassed  = 0;
   bit   in_reset  = 1;
   // Multiplier stand-in pipe
   bit   pv [LAT];
   ent_t pe [LAT];
   int   rob_ctr = 0;

   int total  = 0;
   int passed = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] ex);
      total++;
      if (act === ex) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
   endtask

   // Scoreboard monitor: compare the DUT against the model once the inputs are settled
   always @(negedge clock) begin
      ent_t expe, act;
      bit   ev, from_q;
      #2;
      if (!in_reset) begin
         ev = 0; from_q = 0; expe = '0;
         if (exp_q.size() > 0) begin
            ev = 1; from_q = 1; expe = exp_q[0];
         end
`ifdef MUL_QUEUE_BYPASS_EN
         else if (mul_valid && !squash && m_drop == 0) begin
            ev = 1; expe = {mul_value, mul_prf_idx, mul_rob_idx, mul_PC};
         end
`endif
         act = {mq_value, mq_prf_idx, mq_rob_idx, mq_PC};
         chk("mq_valid", 128'(mq_valid), 128'(ev));
         chk("mq_payload", 128'(act), 128'(expe));
         chk("mq_count", 128'(mq_count), 128'(exp_q.size()));
         chk("mq_free", 128'(mq_free), 128'((exp_q.size() + m_pending) < DEPTH));
         chk("mq_overflow", 128'(mq_overflow), 128'(m_ovf));
         if (ev && cdb_grant && !squash) begin
            if (from_q) void'(exp_q.pop_front());
            else bypassed = 1;
         end
      end
   end

   function automatic ent_t rand_ent();
      ent_t p;
      p.value = $urandom;
      p.prf   = PRF_LEN'($urandom);
      p.rob   = ROB_LEN'(rob_ctr);
      p.pc    = $urandom;
      rob_ctr++;
      return p;
   endfunction

   // One clock cycle: drive the inputs, sample mq_valid, then advance the model
   task automatic step(input bit en, input bit gr, input bit sq, input ent_t pay, output bit v_seen);
      bit   arr;
      ent_t ap;
      int   newp;
      @(negedge clock);
      arr = pv[LAT-1];
      ap  = arr ? pe[LAT-1] : '0;
      mul_enable = en; cdb_grant = gr; squash = sq; mul_valid = arr;
      {mul_value, mul_prf_idx, mul_rob_idx, mul_PC} = ap;
      #3 v_seen = mq_valid;
      @(posedge clock);
      if (arr && !sq) begin
         if (m_drop > 0) m_drop--;
         else if (bypassed) begin end
         else if (exp_q.size() < DEPTH) exp_q.push_back(ap);
         else m_ovf = 1;
      end
      newp = m_pending + int'(en) - int'(arr);
      if (newp < 0) newp = 0;
      if (sq) begin
         exp_q.delete();
         m_drop = newp;
      end
      m_pending = newp;
      bypassed  = 0;
      for (int i = LAT - 1; i > 0; i--) begin
         pv[i] = pv[i-1];
         pe[i] = pe[i-1];
      end
      pv[0] = en;
      pe[0] = pay;
   endtask

   task automatic do_reset();
      @(negedge clock);
      in_reset = 1; reset = 1;
      mul_enable = 0; mul_valid = 0; squash = 0; cdb_grant = 0;
      {mul_value, mul_prf_idx, mul_rob_idx, mul_PC} = '0;
      repeat (2) @(posedge clock);
      exp_q.delete();
      m_pending = 0; m_drop = 0; m_ovf = 0; bypassed = 0;
      for (int i = 0; i < LAT; i++) begin
         pv[i] = 0; pe[i] = '0;
      end
      @(negedge clock);
      reset = 0; in_reset = 0;
   endtask

   task automatic rand_step(input int en_pct, input int gr_pct, input int sq_pct, input bit obey);
      bit en, gr, sq, v;
      bit ok;
      ok = obey ? ((exp_q.size() + m_pending) < DEPTH) : (m_pending < DEPTH);
      en = ($urandom_range(0, 99) < en_pct) && ok;
      gr = $urandom_range(0, 99) < gr_pct;
      sq = $urandom_range(0, 99) < sq_pct;
      step(en, gr, sq, rand_ent(), v);
   endtask

   initial begin
      bit   v;
      int   first;
      ent_t p6;
      for (int i = 0; i < LAT; i++) begin
         pv[i] = 0; pe[i] = '0;
      end
      do_reset();

      // First result latency after an issue at cycle 0
      p6 = rand_ent();
      p6.value = 32'h0000_0006;
      step(1, 0, 0, p6, v);
      first = 0;
      for (int k = 1; k <= 20; k++) begin
         step(0, 0, 0, '0, v);
         if (v) begin
            first = k;
            break;
         end
      end
`ifdef MUL_QUEUE_BYPASS_EN
      chk("first_latency", 128'(first), 128'(8));
`else
      chk("first_latency", 128'(first), 128'(9));
`endif
      repeat (3) step(0, 1, 0, '0, v);

      // Fill to four results with no grant, then force one more arrival
      for (int k = 0; k < 4; k++) step(1, 0, 0, rand_ent(), v);
      repeat (LAT + 2) step(0, 0, 0, '0, v);
      step(1, 0, 0, rand_ent(), v);
      repeat (LAT + 2) step(0, 0, 0, '0, v);
      chk("overflow_sticky", 128'(mq_overflow), 128'(1));
      repeat (6) step(0, 1, 0, '0, v);
      chk("overflow_held", 128'(mq_overflow), 128'(1));
      do_reset();

      // Squash in the same cycle as an issue and an arrival
      for (int k = 0; k < 3; k++) step(1, 0, 0, rand_ent(), v);
      repeat (LAT - 3) step(0, 0, 0, '0, v);
      step(1, 1, 1, rand_ent(), v);
      repeat (LAT + 4) step(0, 1, 0, '0, v);
      step(1, 0, 0, rand_ent(), v);
      repeat (LAT + 3) step(0, 1, 0, '0, v);

      // Randomized phases: fill-biased, drain-biased, squash-heavy, credit-ignoring
      repeat (300) rand_step(50, 20, 2, 1);
      repeat (300) rand_step(60, 80, 2, 1);
      repeat (300) rand_step(70, 40, 8, 1);
      do_reset();
      repeat (300) rand_step(60, 30, 3, 0);
      do_reset();
      repeat (200) rand_step(70, 50, 4, 1);
      repeat (LAT + 6) step(0, 1, 0, '0, v);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
